io_out_uart_tx: RTL and testbench

- Sits directly downstream of the cpu's io_out port, at the top level beside the cpu.
- Detects every change of the 32-bit io_out word and queues the new value in a small word FIFO.
- Serialises each queued word over a UART line as 4 bytes, little-endian, 8N1.
- Gives simulation and FPGA builds a textual trace of program output without probing io_out directly.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_word_fifo.sv | 71 +++++++
 rtl/io_out_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_io_out_uart_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the io_out UART trace path.
//   tx_state_e           : TX FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   UART_DATA_BITS       : data bits per UART character
//   BYTES_PER_WORD       : bytes sent per io_out word
//   DEFAULT_CLKS_PER_BIT : 100 MHz / 115200 baud
package io_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned BYTES_PER_WORD       = 4;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/io_word_fifo.sv
// Synchronous word FIFO.
//   clk, rstn : clock, asynchronous active-low reset
//   push      : write wdata; accepted when not full, or when a pop happens in the same cycle
//   wdata     : word to write
//   pop       : remove head word; ignored when empty
//   rdata     : head word (valid while not empty)
//   full      : level == DEPTH
//   empty     : level == 0
//   level     : occupancy, 0..DEPTH
module io_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LevelFull);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a full FIFO can still take a word.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];
    assign level   = level_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + (PtrW + 1)'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - (PtrW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: contents are only read behind a non-zero level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/io_out_uart_tx.sv
// Watches the cpu io_out word, queues every change and sends each queued word over a UART
// line as 4 little-endian 8N1 bytes.
//   clk, rstn : clock, asynchronous active-low reset
//   io_out    : word driven by the cpu io_out port
//   tx        : UART serial line (registered, idle high)
//   busy      : FIFO non-empty or a frame in flight
//   overflow  : sticky; a changed word was dropped because the FIFO was full
//   level     : current FIFO occupancy
module io_out_uart_tx
    import io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [31:0]                  io_out,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  level
);

    localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitIdxW  = $clog2(UART_DATA_BITS);
    localparam int unsigned ByteIdxW = $clog2(BYTES_PER_WORD);

    localparam logic [CntW-1:0]     CntMax      = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitIdxW-1:0]  BitIdxLast  = BitIdxW'(UART_DATA_BITS - 1);
    localparam logic [ByteIdxW-1:0] ByteIdxLast = ByteIdxW'(BYTES_PER_WORD - 1);

    tx_state_e           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BitIdxW-1:0]  bit_idx_q, bit_idx_d;
    logic [ByteIdxW-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]         shift_word_q, shift_word_d;
    logic [31:0]         prev_word_q;
    logic                tx_q, tx_d;
    logic                overflow_q;

    logic        push;
    logic        pop;
    logic        bit_done;
    logic [7:0]  next_byte;
    logic [31:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;

    // prev_word resets to 0, so a non-zero word at reset release yields one push.
    assign push = (io_out != prev_word_q);
    assign pop  = (state_q == StIdle) && !fifo_empty;

    io_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (io_out),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bit_done = (cnt_q == CntMax);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_word_d = shift_word_q;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_word_d = fifo_rdata;
                    byte_idx_d   = '0;
                    cnt_d        = '0;
                    state_d      = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == BitIdxLast) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + BitIdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (byte_idx_q == ByteIdxLast) begin
                        state_d = StIdle;
                    end else begin
                        byte_idx_d = byte_idx_q + ByteIdxW'(1);
                        state_d    = StStart;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // tx is computed from next-state values and registered, so the line changes exactly
    // on the state/bit boundary edge with no combinational path to the pin.
    assign next_byte = shift_word_d[{byte_idx_d, 3'b000} +: 8];

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = next_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            shift_word_q <= '0;
            prev_word_q  <= '0;
            tx_q         <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_word_q <= shift_word_d;
            prev_word_q  <= io_out;
            tx_q         <= tx_d;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle) || (level != '0);

endmodule

// File: tb/tb_io_out_uart_tx.sv
// Directed bench for io_out_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_out_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic        clk;
    logic        rstn;
    logic [31:0] io_out;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  level;

    int n_checks;
    int n_fail;

    io_out_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .io_out   (io_out),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Steps negedges until tx is low or limit steps have elapsed.
    task automatic wait_start(input int limit, output int waited, output bit found);
        waited = 0;
        found  = 1'b0;
        while (!found && waited < limit) begin
            @(negedge clk);
            waited++;
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    // Receives one 4-byte frame. Offset 0 is the first START cycle of byte 0; the task is
    // entered at start_off and returns at offset 39*C + C/2 (middle of the last STOP bit).
    task automatic rx_frame(input int start_off, output logic [31:0] w, output int framing_err);
        int cur;
        int tgt;
        cur = start_off;
        w = '0;
        framing_err = 0;
        for (int b = 0; b < 4; b++) begin
            tgt = b * 10 * C + C / 2;
            if (tgt >= cur) begin
                repeat (tgt - cur) @(negedge clk);
                cur = tgt;
                if (tx !== 1'b0) framing_err++;
            end
            for (int j = 0; j < 8; j++) begin
                tgt = b * 10 * C + (1 + j) * C + C / 2;
                repeat (tgt - cur) @(negedge clk);
                cur = tgt;
                w[8 * b + j] = tx;
            end
            tgt = b * 10 * C + 9 * C + C / 2;
            repeat (tgt - cur) @(negedge clk);
            cur = tgt;
            if (tx !== 1'b1) framing_err++;
        end
    endtask

    task automatic test_reset;
        int bad;
        rstn = 1'b0;
        io_out = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL idle_hold: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_single_frame;
        logic [31:0] w;
        int ferr;
        io_out = 32'h44434241;
        @(negedge clk);
        n_checks++;
        if (level !== 3'd1) begin n_fail++; $display("FAIL push_level: got %0d want 1", level); end
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL pre_start_tx: got %b want 1", tx); end
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL start_latency: got %b want 0", tx); end
        n_checks++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL pop_level: got %0d want 0", level); end
        rx_frame(0, w, ferr);
        n_checks++;
        if (w !== 32'h44434241) begin
            n_fail++; $display("FAIL frame_bytes: got %h want 44434241", w);
        end
        n_checks++;
        if (ferr !== 0) begin n_fail++; $display("FAIL frame_framing: got %0d want 0", ferr); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_last_stop: got %b want 1", busy); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_drop: got %b want 0", busy); end
    endtask

    task automatic test_burst;
        logic [31:0] w;
        int ferr;
        int waited;
        bit found;
        io_out = 32'h1;
        @(negedge clk);
        io_out = 32'h2;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL burst_start: got %b want 0", tx); end
        io_out = 32'h3;
        @(negedge clk);
        io_out = 32'h4;
        @(negedge clk);
        io_out = 32'h5;
        @(negedge clk);
        n_checks++;
        if (level !== 3'd4) begin n_fail++; $display("FAIL burst_peak: got %0d want 4", level); end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL burst_overflow: got %b want 0", overflow);
        end
        rx_frame(3, w, ferr);
        n_checks++;
        if (w !== 32'h1 || ferr !== 0) begin
            n_fail++; $display("FAIL burst_word1: got %h/%0d want 00000001/0", w, ferr);
        end
        for (int i = 2; i <= 5; i++) begin
            wait_start(20, waited, found);
            n_checks++;
            if (!found || waited !== 3) begin
                n_fail++; $display("FAIL b2b_gap: got %0d found=%b want 3", waited, found);
            end
            rx_frame(0, w, ferr);
            n_checks++;
            if (w !== 32'(i) || ferr !== 0) begin
                n_fail++; $display("FAIL burst_word%0d: got %h/%0d want %h/0", i, w, ferr, i);
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow;
        logic [31:0] w;
        int ferr;
        int waited;
        bit found;
        io_out = 32'h100;
        @(negedge clk);
        io_out = 32'h101;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL ovf_frame_start: got %b want 0", tx); end
        io_out = 32'h102;
        @(negedge clk);
        io_out = 32'h103;
        @(negedge clk);
        io_out = 32'h104;
        @(negedge clk);
        n_checks++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full: got level %0d ovf %b want 4/0", level, overflow);
        end
        io_out = 32'h6;
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_checks++;
        if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", level); end
        rx_frame(4, w, ferr);
        n_checks++;
        if (w !== 32'h100 || ferr !== 0) begin
            n_fail++; $display("FAIL ovf_word0: got %h/%0d want 00000100/0", w, ferr);
        end
        for (int i = 1; i <= 4; i++) begin
            wait_start(20, waited, found);
            rx_frame(0, w, ferr);
            n_checks++;
            if (!found || w !== 32'h100 + 32'(i) || ferr !== 0) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got %h/%0d found=%b want %h/0", i, w, ferr, found,
                         32'h100 + 32'(i));
            end
        end
        wait_start(300, waited, found);
        n_checks++;
        if (found !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped_sent: got a frame want none"); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_mid_reset;
        logic [31:0] w;
        int ferr;
        int waited;
        bit found;
        io_out = 32'hA5C30F81;
        wait_start(10, waited, found);
        n_checks++;
        if (!found || waited !== 2) begin
            n_fail++; $display("FAIL mr_start: got %0d found=%b want 2", waited, found);
        end
        // Queue two more words so the reset has something to discard.
        repeat (10) @(negedge clk);
        io_out = 32'h0BADF00D;
        @(negedge clk);
        io_out = 32'hA5C30F81;
        // Offset 95: third data bit of byte 2 (0xC3 bit 2 = 0).
        repeat (95 - 11) @(negedge clk);
        n_checks++;
        if (tx !== 1'b0 || level !== 3'd2) begin
            n_fail++; $display("FAIL mr_pre: got tx %b level %0d want 0/2", tx, level);
        end
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL mr_tx_async: got %b want 1", tx); end
        n_checks++;
        if (level !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_clear: got level %0d busy %b ovf %b want 0/0/0", level, busy, overflow);
        end
        @(negedge clk);
        rstn = 1'b1;
        wait_start(10, waited, found);
        n_checks++;
        if (!found || waited !== 2) begin
            n_fail++; $display("FAIL mr_restart: got %0d found=%b want 2", waited, found);
        end
        rx_frame(0, w, ferr);
        n_checks++;
        if (w !== 32'hA5C30F81 || ferr !== 0) begin
            n_fail++; $display("FAIL mr_word: got %h/%0d want a5c30f81/0", w, ferr);
        end
        wait_start(300, waited, found);
        n_checks++;
        if (found !== 1'b0) begin n_fail++; $display("FAIL mr_extra_frame: got a frame want none"); end
    endtask

    task automatic test_hold;
        logic [31:0] w;
        int ferr;
        int waited;
        bit found;
        io_out = 32'h12345678;
        wait_start(10, waited, found);
        n_checks++;
        if (!found || waited !== 2) begin
            n_fail++; $display("FAIL hold_start: got %0d found=%b want 2", waited, found);
        end
        rx_frame(0, w, ferr);
        n_checks++;
        if (w !== 32'h12345678 || ferr !== 0) begin
            n_fail++; $display("FAIL hold_word: got %h/%0d want 12345678/0", w, ferr);
        end
        wait_start(1000, waited, found);
        n_checks++;
        if (found !== 1'b0) begin n_fail++; $display("FAIL hold_repeat: got a frame want none"); end
        n_checks++;
        if (busy !== 1'b0 || level !== 3'd0) begin
            n_fail++; $display("FAIL hold_idle: got busy %b level %0d want 0/0", busy, level);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rstn = 1'b0;
        io_out = 32'h0;
        test_reset();
        test_single_frame();
        test_burst();
        test_overflow();
        test_mid_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
